uart_rx_drain: RTL and testbench
================================

UART_RX_DRAIN -- requirements
Module: uart_rx_drain

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, output FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter POLL_GAP, default 4, idle cycles between control-register polls (1..255).
REQ-003 SHALL have port clock  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port enable  in  1  high allows polling; low finishes any in-flight transaction, then parks in IDLE.
REQ-006 SHALL have port uart_cs  out  1  UART_Component chip select, active low.
REQ-007 SHALL have port uart_rd_strobe  out  1  read strobe, one-cycle high pulse.
REQ-008 SHALL have port uart_wr  out  1  write enable, active low; constant 1.
REQ-009 SHALL have port uart_addr  out  3  register address: 3'b000 control, 3'b001 rx buffer.
REQ-010 SHALL have port uart_rd_busy  in  1  component read busy, active high.
REQ-011 SHALL have port uart_out_data  in  8  component read data.
REQ-012 SHALL have port byte_valid  out  1  FIFO head valid.
REQ-013 SHALL have port byte_data  out  8  FIFO head byte.
REQ-014 SHALL have port byte_ready  in  1  consumer accept; pop when byte_valid and byte_ready both high.
REQ-015 SHALL have port fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-016 SHALL have port fifo_full  out  1  occupancy equals FIFO_DEPTH.

Function
REQ-017 SHALL implement FSM states IDLE, POLL_SEL, POLL_STB, POLL_CHK, READ_SEL, READ_STB, READ_CAP, GAP.
REQ-018 IDLE -> POLL_SEL when enable=1 and fifo_full=0; otherwise remain in IDLE.
REQ-019 POLL_SEL: uart_cs=0, uart_addr=000, strobe=0; -> POLL_STB next cycle.
REQ-020 POLL_STB: uart_cs=0, uart_addr=000, strobe=1 for exactly one cycle; -> POLL_CHK.
REQ-021 POLL_CHK: uart_cs=0; hold while uart_rd_busy=1; when busy=0 sample uart_out_data[2] (byte-arrived): 1 -> READ_SEL, 0 -> GAP.
REQ-022 READ_SEL/READ_STB: same as POLL_SEL/POLL_STB with uart_addr=001.
REQ-023 READ_CAP: uart_cs=0; hold while busy=1; when busy=0 push uart_out_data into the FIFO; -> GAP.
REQ-024 GAP: uart_cs=1; count POLL_GAP cycles, then -> POLL_SEL if enable=1 and not full, else IDLE.
REQ-025 Outside POLL_*/READ_* states, uart_cs=1, strobe=0, uart_addr=000.
REQ-026 Poll-to-push latency with busy=0 and byte present SHALL be 6 cycles (POLL_SEL to READ_CAP inclusive).
REQ-027 A read of the rx buffer SHALL only start when the FIFO has a free slot at POLL_CHK; no byte is ever dropped by this block.
REQ-028 FIFO is first-word-fall-through: byte_data is valid in the same cycle that byte_valid is high.
REQ-029 Simultaneous push and pop SHALL leave fifo_count unchanged; a push into a full FIFO is impossible by construction, and a pop when empty is ignored.
REQ-030 Read/write pointers wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH.
REQ-031 Deasserting enable mid-transaction SHALL NOT abort strobe/capture; the block completes to GAP, then enters IDLE.

Reset
REQ-032 On reset=0 at a clock edge: state=IDLE, uart_cs=1, strobe=0, uart_addr=000, FIFO empty, byte_valid=0, fifo_count=0, fifo_full=0, gap counter=0.
REQ-033 Reset mid-transaction SHALL abandon the transaction and flush the FIFO within the same edge.

Structure
REQ-034 Package uart_drain_pkg SHALL hold the FSM state enum, CTRL_ADDR=3'b000, RXBUF_ADDR=3'b001, and BYTE_ARRIVED_BIT=2.
REQ-035 FIFO SHALL be a sub-module, sync_fifo, parameterised by width (8) and depth, with synchronous active-low reset.

Verification
REQ-036 Control reads 0x00 repeatedly -> strobes only at addr 000, separated by POLL_GAP+3 cycles, byte_valid stays 0.
REQ-037 Control 0x04, then rx buffer 0x3B, byte_ready=1 -> addr 001 strobed once, byte_data=0x3B with byte_valid on the cycle after READ_CAP.
REQ-038 Eight bytes 0x10..0x17 arrive, byte_ready=0 -> fifo_full=1, fifo_count=8, no further strobes; raise byte_ready -> pops 0x10..0x17 in order, polling resumes.
REQ-039 uart_rd_busy held high 3 cycles in READ_CAP -> capture is delayed 3 cycles, byte is pushed once, strobe is not repeated.
REQ-040 reset=0 during READ_STB with 2 entries queued -> next cycle uart_cs=1, fifo_count=0, byte_valid=0, state IDLE.

Source files
------------

// File: rtl/uart_rx_drain_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : uart_drain_pkg                                               |
// | Description : Shared definitions for the UART receive drain: register      |
// |               addresses of the UART component, the status bit that flags   |
// |               an arrived byte, and the drain FSM state encoding.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package uart_drain_pkg;

   localparam logic [2:0] CTRL_ADDR        = 3'b000;
   localparam logic [2:0] RXBUF_ADDR       = 3'b001;
   localparam int         BYTE_ARRIVED_BIT = 2;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      POLL_SEL = 3'd1,
      POLL_STB = 3'd2,
      POLL_CHK = 3'd3,
      READ_SEL = 3'd4,
      READ_STB = 3'd5,
      READ_CAP = 3'd6,
      GAP      = 3'd7
   } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_drain_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : uart_rx_drain_if                                             |
// | Description : Register-access bus of the UART component.                   |
// |   uart_cs        chip select, active low          (master -> slave)        |
// |   uart_rd_strobe one-cycle read strobe            (master -> slave)        |
// |   uart_wr        write enable, active low         (master -> slave)        |
// |   uart_addr      register address                 (master -> slave)        |
// |   uart_rd_busy   read busy, active high           (slave  -> master)       |
// |   uart_out_data  read data                        (slave  -> master)       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface uart_rx_drain_if;

   logic       uart_cs;
   logic       uart_rd_strobe;
   logic       uart_wr;
   logic [2:0] uart_addr;
   logic       uart_rd_busy;
   logic [7:0] uart_out_data;

   modport master (
      output uart_cs, uart_rd_strobe, uart_wr, uart_addr,
      input  uart_rd_busy, uart_out_data
   );

   modport slave (
      input  uart_cs, uart_rd_strobe, uart_wr, uart_addr,
      output uart_rd_busy, uart_out_data
   );

endinterface
`default_nettype wire

// File: rtl/uart_rx_drain_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_fifo                                                    |
// | Description : Single-clock first-word-fall-through FIFO.                   |
// |   clock       system clock                                                 |
// |   reset       synchronous reset, active low; flushes the FIFO              |
// |   push        write push_data (ignored when full)                          |
// |   push_data   data to write                                                |
// |   pop         remove head entry (ignored when empty)                       |
// |   head_data   current head entry, valid while head_valid is high           |
// |   head_valid  FIFO not empty                                               |
// |   count       occupancy, 0..DEPTH                                          |
// |   full        occupancy equals DEPTH                                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  wire logic                     clock,
   input  wire logic                     reset,
   input  wire logic                     push,
   input  wire logic [WIDTH-1:0]         push_data,
   input  wire logic                     pop,
   output logic      [WIDTH-1:0]         head_data,
   output logic                          head_valid,
   output logic      [$clog2(DEPTH):0]   count,
   output logic                          full
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push = push && (r_count != FULL_CNT);
   assign w_pop  = pop  && (r_count != '0);

   // Storage needs no reset: entries are only visible through r_count.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Pointers are exactly AW bits wide so they wrap modulo DEPTH.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign head_data  = r_mem[r_rd_ptr];
   assign head_valid = (r_count != '0);
   assign count      = r_count;
   assign full       = (r_count == FULL_CNT);

endmodule
`default_nettype wire

// File: rtl/uart_rx_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_drain                                                |
// | Description : Polls the UART component control register; whenever the     |
// |               byte-arrived flag is set and there is room, reads the rx     |
// |               buffer and pushes the byte into an output FWFT FIFO.         |
// |   clock       system clock, rising edge                                    |
// |   reset       synchronous reset, active low                                |
// |   enable      allow polling; low parks in IDLE after the current access    |
// |   uart        UART component register bus (master side)                    |
// |   byte_valid  FIFO head valid                                              |
// |   byte_data   FIFO head byte                                               |
// |   byte_ready  consumer accept; pops when byte_valid is high                |
// |   fifo_count  FIFO occupancy                                               |
// |   fifo_full   FIFO occupancy equals FIFO_DEPTH                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_rx_drain
   import uart_drain_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int POLL_GAP   = 4
) (
   input  wire logic                          clock,
   input  wire logic                          reset,
   input  wire logic                          enable,
   uart_rx_drain_if.master                    uart,
   output logic                               byte_valid,
   output logic      [7:0]                    byte_data,
   input  wire logic                          byte_ready,
   output logic      [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                               fifo_full
);

   localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

   drain_state_t r_state;
   logic         r_cs;
   logic         r_strobe;
   logic [2:0]   r_addr;
   logic [7:0]   r_gap_cnt;
   logic         w_push;

   // Capture happens in the first non-busy cycle of READ_CAP; the FIFO
   // registers the byte on the same edge that moves the FSM to GAP.
   assign w_push = (r_state == READ_CAP) && !uart.uart_rd_busy;

   // Bus outputs are registered from the next state so that they are
   // aligned with the state they belong to.
   always_ff @(posedge clock) begin
      drain_state_t next_state;
      if (!reset) begin
         r_state   <= IDLE;
         r_cs      <= 1'b1;
         r_strobe  <= 1'b0;
         r_addr    <= CTRL_ADDR;
         r_gap_cnt <= '0;
      end else begin
         next_state = r_state;
         r_gap_cnt <= '0;
         case (r_state)
            IDLE: begin
               if (enable && !fifo_full) begin
                  next_state = POLL_SEL;
               end
            end
            POLL_SEL: next_state = POLL_STB;
            POLL_STB: next_state = POLL_CHK;
            POLL_CHK: begin
               // A read is only started when the FIFO can take the byte,
               // so the push in READ_CAP can never be lost.
               if (!uart.uart_rd_busy) begin
                  if (uart.uart_out_data[BYTE_ARRIVED_BIT] && !fifo_full) begin
                     next_state = READ_SEL;
                  end else begin
                     next_state = GAP;
                  end
               end
            end
            READ_SEL: next_state = READ_STB;
            READ_STB: next_state = READ_CAP;
            READ_CAP: begin
               if (!uart.uart_rd_busy) begin
                  next_state = GAP;
               end
            end
            GAP: begin
               if (r_gap_cnt == GAP_LAST) begin
                  next_state = (enable && !fifo_full) ? POLL_SEL : IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 8'd1;
               end
            end
            default: next_state = IDLE;
         endcase

         r_state  <= next_state;
         r_cs     <= (next_state == IDLE) || (next_state == GAP);
         r_strobe <= (next_state == POLL_STB) || (next_state == READ_STB);
         r_addr   <= ((next_state == READ_SEL) || (next_state == READ_STB) ||
                      (next_state == READ_CAP)) ? RXBUF_ADDR : CTRL_ADDR;
      end
   end

   assign uart.uart_cs        = r_cs;
   assign uart.uart_rd_strobe = r_strobe;
   assign uart.uart_wr        = 1'b1;
   assign uart.uart_addr      = r_addr;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (w_push),
      .push_data  (uart.uart_out_data),
      .pop        (byte_ready),
      .head_data  (byte_data),
      .head_valid (byte_valid),
      .count      (fifo_count),
      .full       (fifo_full)
   );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_drain                                             |
// | Description : Directed self-checking bench for uart_rx_drain with a small  |
// |               behavioural UART component (register mux + busy stretcher). |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_uart_rx_drain;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       byte_ready;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic [3:0] fifo_count;
   logic       fifo_full;

   // Component model controls
   logic [7:0] ctrl_val;
   logic [7:0] rx_base;
   int         rx_mark;
   int         busy_len;
   logic [7:0] rx_cur;

   // Monitor state (written only by the monitor process)
   int         cyc = 0;
   int         n_ctrl = 0;
   int         n_rx = 0;
   int         last_ctrl = 0;
   int         prev_ctrl = 0;
   int         last_rx = 0;
   int         valid_rise = 0;
   logic       prev_valid = 1'b0;
   int         busy_left = 0;
   int         pop_n = 0;
   logic [7:0] pop_log [64];

   int vectors = 0;
   int errors  = 0;
   int nc;
   int pm;

   uart_rx_drain_if bus ();

   uart_rx_drain #(
      .FIFO_DEPTH (8),
      .POLL_GAP   (4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .uart       (bus),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .fifo_count (fifo_count),
      .fifo_full  (fifo_full)
   );

   always #5 clock = ~clock;

   // rx buffer returns rx_base for the first read after rx_mark, then +1 per read
   always_comb rx_cur = rx_base + 8'(n_rx - rx_mark - 1);
   assign bus.uart_out_data = (bus.uart_addr == 3'b001) ? rx_cur : ctrl_val;
   assign bus.uart_rd_busy  = (busy_left != 0);

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (bus.uart_rd_strobe && bus.uart_addr == 3'b000) begin
         n_ctrl    <= n_ctrl + 1;
         prev_ctrl <= last_ctrl;
         last_ctrl <= cyc;
      end
      if (bus.uart_rd_strobe && bus.uart_addr == 3'b001) begin
         n_rx      <= n_rx + 1;
         last_rx   <= cyc;
         busy_left <= busy_len;
      end else if (busy_left != 0) begin
         busy_left <= busy_left - 1;
      end
      if (byte_valid && !prev_valid) valid_rise <= cyc;
      prev_valid <= byte_valid;
      if (byte_valid && byte_ready) begin
         pop_log[pop_n[5:0]] <= byte_data;
         pop_n <= pop_n + 1;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; byte_ready = 1'b0;
      ctrl_val = 8'h00; rx_base = 8'h00; rx_mark = 0; busy_len = 0;
      tick(); tick(); tick();

      // Reset state
      check("rst_cs",    32'(bus.uart_cs), 32'd1);
      check("rst_stb",   32'(bus.uart_rd_strobe), 32'd0);
      check("rst_addr",  32'(bus.uart_addr), 32'd0);
      check("rst_wr",    32'(bus.uart_wr), 32'd1);
      check("rst_valid", 32'(byte_valid), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_full",  32'(fifo_full), 32'd0);

      // Empty control register: only control polls, POLL_GAP+3 apart
      reset = 1'b1; enable = 1'b1;
      for (int i = 0; i < 30; i++) tick();
      check("idle_polls",   32'(n_ctrl >= 3), 32'd1);
      check("idle_period",  32'(last_ctrl - prev_ctrl), 32'd7);
      check("idle_no_read", 32'(n_rx), 32'd0);
      check("idle_valid",   32'(byte_valid), 32'd0);

      // Single byte 0x3B, consumer ready
      byte_ready = 1'b1; rx_base = 8'h3B; rx_mark = n_rx; pm = pop_n;
      ctrl_val = 8'h04;
      for (int i = 0; i < 40 && n_rx == rx_mark; i++) tick();
      ctrl_val = 8'h00;
      check("one_rx_strobe", 32'(n_rx), 32'(rx_mark + 1));
      check("one_chk_to_rd", 32'(last_rx - last_ctrl), 32'd3);
      for (int i = 0; i < 10; i++) tick();
      check("one_rx_once",   32'(n_rx), 32'(rx_mark + 1));
      check("one_pops",      32'(pop_n), 32'(pm + 1));
      check("one_data",      32'(pop_log[pm[5:0]]), 32'h3B);
      check("one_latency",   32'(valid_rise - last_rx), 32'd2);

      // Fill the FIFO with 0x10..0x17 while the consumer stalls
      byte_ready = 1'b0; rx_base = 8'h10; rx_mark = n_rx;
      ctrl_val = 8'h04;
      for (int i = 0; i < 200 && !fifo_full; i++) tick();
      ctrl_val = 8'h00;
      check("fill_full",  32'(fifo_full), 32'd1);
      check("fill_count", 32'(fifo_count), 32'd8);
      check("fill_head",  32'(byte_data), 32'h10);
      nc = n_ctrl;
      for (int i = 0; i < 30; i++) tick();
      check("fill_reads",     32'(n_rx), 32'(rx_mark + 8));
      check("fill_no_polls",  32'(n_ctrl), 32'(nc));
      pm = pop_n;
      byte_ready = 1'b1;
      for (int i = 0; i < 30; i++) tick();
      for (int i = 0; i < 8; i++)
         check($sformatf("drain_%0d", i), 32'(pop_log[6'(pm + i)]), 32'(8'h10 + i));
      check("drain_count",   32'(fifo_count), 32'd0);
      check("drain_resumed", 32'(n_ctrl > nc), 32'd1);

      // Busy held 3 cycles in READ_CAP; enable dropped mid-transaction
      byte_ready = 1'b0; busy_len = 3; rx_base = 8'hA5; rx_mark = n_rx;
      ctrl_val = 8'h04;
      for (int i = 0; i < 40 && n_rx == rx_mark; i++) tick();
      enable = 1'b0; ctrl_val = 8'h00; nc = n_ctrl;
      for (int i = 0; i < 20; i++) tick();
      check("busy_latency",  32'(valid_rise - last_rx), 32'd5);
      check("busy_rx_once",  32'(n_rx), 32'(rx_mark + 1));
      check("busy_count",    32'(fifo_count), 32'd1);
      check("busy_data",     32'(byte_data), 32'hA5);
      check("dis_no_polls",  32'(n_ctrl), 32'(nc));
      check("dis_cs",        32'(bus.uart_cs), 32'd1);

      // Reset during READ_STB with two entries queued
      busy_len = 0; rx_base = 8'hB6; rx_mark = n_rx;
      enable = 1'b1; ctrl_val = 8'h04;
      for (int i = 0; i < 40 && fifo_count != 4'd2; i++) tick();
      check("pre_count2", 32'(fifo_count), 32'd2);
      for (int i = 0; i < 40 && !(bus.uart_rd_strobe && bus.uart_addr == 3'b001); i++) tick();
      check("pre_rd_stb", 32'(bus.uart_rd_strobe && bus.uart_addr == 3'b001), 32'd1);
      reset = 1'b0;
      tick();
      check("mrst_cs",    32'(bus.uart_cs), 32'd1);
      check("mrst_stb",   32'(bus.uart_rd_strobe), 32'd0);
      check("mrst_addr",  32'(bus.uart_addr), 32'd0);
      check("mrst_count", 32'(fifo_count), 32'd0);
      check("mrst_valid", 32'(byte_valid), 32'd0);
      check("mrst_full",  32'(fifo_full), 32'd0);
      reset = 1'b1; enable = 1'b0; ctrl_val = 8'h00; nc = n_ctrl;
      for (int i = 0; i < 10; i++) tick();
      check("post_idle_polls", 32'(n_ctrl), 32'(nc));
      check("post_idle_cs",    32'(bus.uart_cs), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
